// File: rtl/reg_status_file_pkg.sv
// Shared configuration for the register/status file slice.
// Default geometry used by the top and the read ports.
package reg_status_file_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int TAG_W_DEF = 4;
  localparam int NRD_DEF   = 2;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: commit bypass, x0 and flush masking.
// The caller selects the stored entry; this block only qualifies it.
module regfile_read_port
  import reg_status_file_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int AW    = AW_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic [AW-1:0]    addr,
  input  logic             cmt_en,
  input  logic [AW-1:0]    cmt_addr,
  input  logic [XLEN-1:0]  cmt_data,
  input  logic [TAG_W-1:0] cmt_tag,
  input  logic [XLEN-1:0]  ent_data,
  input  logic             ent_busy,
  input  logic [TAG_W-1:0] ent_tag,
  output logic [XLEN-1:0]  data,
  output logic             busy,
  output logic [TAG_W-1:0] tag
);

  logic hit;

  assign hit = rdy && cmt_en && (addr == cmt_addr);

  always_comb begin
    data = '0;
    busy = 1'b0;
    tag  = '0;
    if (!rst && addr != '0) begin
      data = hit ? cmt_data : ent_data;
      // a matching commit this cycle retires the pending producer
      busy = ent_busy && !(hit && ent_tag == cmt_tag) && !flush;
      tag  = busy ? ent_tag : '0;
    end
  end

endmodule

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status
// (busy + ROB tag), commit bypass and a running busy count.
module reg_status_file
  import reg_status_file_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int NRD   = NRD_DEF,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic                 cmt_en,
  input  logic [AW-1:0]        cmt_addr,
  input  logic [XLEN-1:0]      cmt_data,
  input  logic [TAG_W-1:0]     cmt_tag,
  input  logic                 ren_en,
  input  logic [AW-1:0]        ren_addr,
  input  logic [TAG_W-1:0]     ren_tag,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  output logic [NRD*TAG_W-1:0] rd_tag,
  output logic [AW:0]          num_busy
);

  localparam logic [AW:0] ONE = (AW + 1)'(1);

  logic [XLEN-1:0]  val_a [NREGS];
  logic [TAG_W-1:0] tag_a [NREGS];
  logic [NREGS-1:0] busy_v;

  logic        cmt_ok;
  logic        ren_ok;
  logic        cmt_clr;
  logic        inc;
  logic        dec;
  logic [AW:0] nb_q;
  logic [AW:0] nb_d;

  assign cmt_ok  = cmt_en && (cmt_addr != '0);
  assign ren_ok  = ren_en && (ren_addr != '0);
  assign cmt_clr = cmt_ok && busy_v[cmt_addr]
                && (tag_a[cmt_addr] == cmt_tag);

  assign val_a[0]  = '0;
  assign tag_a[0]  = '0;
  assign busy_v[0] = 1'b0;

  for (genvar i = 1; i < NREGS; i++) begin : g_ent
    logic [XLEN-1:0]  val_q;
    logic             busy_q;
    logic [TAG_W-1:0] tag_q;
    logic             wr;
    logic             clr;
    logic             rn;

    assign wr  = cmt_en && (cmt_addr == AW'(i));
    assign clr = wr && busy_q && (tag_q == cmt_tag);
    assign rn  = ren_en && (ren_addr == AW'(i));

    always_ff @(posedge clk) begin
      if (rst) begin
        val_q  <= '0;
        busy_q <= 1'b0;
        tag_q  <= '0;
      end else if (rdy) begin
        if (wr)
          val_q <= cmt_data;
        // rename outranks a same-cycle commit to the same register
        if (flush) begin
          busy_q <= 1'b0;
          tag_q  <= '0;
        end else if (rn) begin
          busy_q <= 1'b1;
          tag_q  <= ren_tag;
        end else if (clr) begin
          busy_q <= 1'b0;
          tag_q  <= '0;
        end
      end
    end

    assign val_a[i]  = val_q;
    assign tag_a[i]  = tag_q;
    assign busy_v[i] = busy_q;
  end

  // +1 only when a free register becomes busy; -1 only when a
  // retiring register is not simultaneously re-renamed
  assign inc = ren_ok && !busy_v[ren_addr];
  assign dec = cmt_clr && !(ren_ok && ren_addr == cmt_addr);

  always_comb begin
    nb_d = nb_q;
    if (inc && !dec)
      nb_d = nb_q + ONE;
    else if (dec && !inc)
      nb_d = nb_q - ONE;
  end

  always_ff @(posedge clk) begin
    if (rst)
      nb_q <= '0;
    else if (rdy)
      nb_q <= flush ? '0 : nb_d;
  end

  assign num_busy = nb_q;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] ra;

    assign ra = rd_addr[p*AW +: AW];

    regfile_read_port #(
      .XLEN  (XLEN),
      .AW    (AW),
      .TAG_W (TAG_W)
    ) u_port (
      .rst      (rst),
      .rdy      (rdy),
      .flush    (flush),
      .addr     (ra),
      .cmt_en   (cmt_en),
      .cmt_addr (cmt_addr),
      .cmt_data (cmt_data),
      .cmt_tag  (cmt_tag),
      .ent_data (val_a[ra]),
      .ent_busy (busy_v[ra]),
      .ent_tag  (tag_a[ra]),
      .data     (rd_data[p*XLEN +: XLEN]),
      .busy     (rd_busy[p]),
      .tag      (rd_tag[p*TAG_W +: TAG_W])
    );
  end

endmodule

// File: tb/tb_reg_status_file.sv
// Scoreboard bench for reg_status_file: directed scenarios
// plus a reference-model random run.
module tb_reg_status_file;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int TAG_W = 4;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 rdy;
  logic                 flush;
  logic                 cmt_en;
  logic [AW-1:0]        cmt_addr;
  logic [XLEN-1:0]      cmt_data;
  logic [TAG_W-1:0]     cmt_tag;
  logic                 ren_en;
  logic [AW-1:0]        ren_addr;
  logic [TAG_W-1:0]     ren_tag;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NRD*TAG_W-1:0] rd_tag;
  logic [AW:0]          num_busy;

  reg_status_file #(
    .XLEN(XLEN), .NREGS(NREGS), .TAG_W(TAG_W), .NRD(NRD)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .cmt_en(cmt_en), .cmt_addr(cmt_addr),
    .cmt_data(cmt_data), .cmt_tag(cmt_tag),
    .ren_en(ren_en), .ren_addr(ren_addr), .ren_tag(ren_tag),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .rd_tag(rd_tag), .num_busy(num_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            nm;
    logic [XLEN-1:0]  d;
    logic             b;
    logic [TAG_W-1:0] t;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  // model for the random run
  logic [XLEN-1:0]  mval  [NREGS];
  logic             mbusy [NREGS];
  logic [TAG_W-1:0] mtag  [NREGS];

  task automatic idle();
    rdy = 1'b1; flush = 1'b0;
    cmt_en = 1'b0; cmt_addr = '0; cmt_data = '0; cmt_tag = '0;
    ren_en = 1'b0; ren_addr = '0; ren_tag = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic push(input string nm, input logic [XLEN-1:0] d,
                      input logic b, input logic [TAG_W-1:0] t);
    exp_t e;
    e.nm = nm; e.d = d; e.b = b; e.t = t;
    sb.push_back(e);
  endtask

  task automatic cmt(input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                     input logic [TAG_W-1:0] t);
    cmt_en = 1'b1; cmt_addr = a; cmt_data = d; cmt_tag = t;
  endtask

  task automatic ren(input logic [AW-1:0] a, input logic [TAG_W-1:0] t);
    ren_en = 1'b1; ren_addr = a; ren_tag = t;
  endtask

  task automatic test_reset();
    exp_t e;
    idle(); rst = 1'b1; rd(5'd5, 5'd5);
    step(); step();
    push("rst_hold_p0", '0, 1'b0, '0);
    push("rst_hold_p1", '0, 1'b0, '0);
    #3;
    for (int p = 0; p < NRD; p++) begin
      e = sb.pop_front(); n_run++;
      if (rd_data[p*XLEN +: XLEN] !== e.d || rd_busy[p] !== e.b
          || rd_tag[p*TAG_W +: TAG_W] !== e.t) begin
        n_fail++;
        $display("FAIL %s got d=%h b=%b t=%h want d=%h b=%b t=%h", e.nm,
          rd_data[p*XLEN +: XLEN], rd_busy[p], rd_tag[p*TAG_W +: TAG_W],
          e.d, e.b, e.t);
      end
    end
    rst = 1'b0;
    step();
    push("rst_x5_p0", '0, 1'b0, '0);
    push("rst_x5_p1", '0, 1'b0, '0);
    #3;
    for (int p = 0; p < NRD; p++) begin
      e = sb.pop_front(); n_run++;
      if (rd_data[p*XLEN +: XLEN] !== e.d || rd_busy[p] !== e.b
          || rd_tag[p*TAG_W +: TAG_W] !== e.t) begin
        n_fail++;
        $display("FAIL %s got d=%h b=%b t=%h want d=%h b=%b t=%h", e.nm,
          rd_data[p*XLEN +: XLEN], rd_busy[p], rd_tag[p*TAG_W +: TAG_W],
          e.d, e.b, e.t);
      end
    end
    n_run++;
    if (num_busy !== 6'd0) begin
      n_fail++;
      $display("FAIL rst_num_busy got %0d want 0", num_busy);
    end
  endtask

  task automatic test_rename_commit();
    exp_t e;
    idle(); ren(5'd3, 4'd7); rd(5'd3, 5'd3);
    push("ren_same_cyc_p0", '0, 1'b0, '0);
    push("ren_same_cyc_p1", '0, 1'b0, '0);
    #3;
    for (int p = 0; p < NRD; p++) begin
      e = sb.pop_front(); n_run++;
      if (rd_data[p*XLEN +: XLEN] !== e.d || rd_busy[p] !== e.b
          || rd_tag[p*TAG_W +: TAG_W] !== e.t) begin
        n_fail++;
        $display("FAIL %s got d=%h b=%b t=%h want d=%h b=%b t=%h", e.nm,
          rd_data[p*XLEN +: XLEN], rd_busy[p], rd_tag[p*TAG_W +: TAG_W],
          e.d, e.b, e.t);
      end
    end
    step(); idle(); rd(5'd3, 5'd0);
    push("ren_x3_p0", '0, 1'b1, 4'd7);
    push("ren_x0_p1", '0, 1'b0, '0);
    #3;
    for (int p = 0; p < NRD; p++) begin
      e = sb.pop_front(); n_run++;
      if (rd_data[p*XLEN +: XLEN] !== e.d || rd_busy[p] !== e.b
          || rd_tag[p*TAG_W +: TAG_W] !== e.t) begin
        n_fail++;
        $display("FAIL %s got d=%h b=%b t=%h want d=%h b=%b t=%h", e.nm,
          rd_data[p*XLEN +: XLEN], rd_busy[p], rd_tag[p*TAG_W +: TAG_W],
          e.d, e.b, e.t);
      end
    end
    n_run++;
    if (num_busy !== 6'd1) begin
      n_fail++;
      $display("FAIL ren_num_busy got %0d want 1", num_busy);
    end
    cmt(5'd3, 32'hDEADBEEF, 4'd7); rd(5'd3, 5'd3);
    push("cmt_bypass_p0", 32'hDEADBEEF, 1'b0, '0);
    push("cmt_bypass_p1", 32'hDEADBEEF, 1'b0, '0);
    #3;
    for (int p = 0; p < NRD; p++) begin
      e = sb.pop_front(); n_run++;
      if (rd_data[p*XLEN +: XLEN] !== e.d || rd_busy[p] !== e.b
          || rd_tag[p*TAG_W +: TAG_W] !== e.t) begin
        n_fail++;
        $display("FAIL %s got d=%h b=%b t=%h want d=%h b=%b t=%h", e.nm,
          rd_data[p*XLEN +: XLEN], rd_busy[p], rd_tag[p*TAG_W +: TAG_W],
          e.d, e.b, e.t);
      end
    end
    step(); idle();
    n_run++;
    if (num_busy !== 6'd0) begin
      n_fail++;
      $display("FAIL cmt_num_busy got %0d want 0", num_busy);
    end
  endtask

  task automatic test_tag_mismatch();
    exp_t e;
    idle(); ren(5'd4, 4'd2); step();
    ren(5'd4, 4'd5); step();
    idle(); cmt(5'd4, 32'h11, 4'd2); rd(5'd4, 5'd4);
    push("stale_byp_p0", 32'h11, 1'b1, 4'd5);
    push("stale_byp_p1", 32'h11, 1'b1, 4'd5);
    #3;
    for (int p = 0; p < NRD; p++) begin
      e = sb.pop_front(); n_run++;
      if (rd_data[p*XLEN +: XLEN] !== e.d || rd_busy[p] !== e.b
          || rd_tag[p*TAG_W +: TAG_W] !== e.t) begin
        n_fail++;
        $display("FAIL %s got d=%h b=%b t=%h want d=%h b=%b t=%h", e.nm,
          rd_data[p*XLEN +: XLEN], rd_busy[p], rd_tag[p*TAG_W +: TAG_W],
          e.d, e.b, e.t);
      end
    end
    step(); idle(); rd(5'd4, 5'd3);
    push("stale_x4_p0", 32'h11, 1'b1, 4'd5);
    push("stale_x3_p1", 32'hDEADBEEF, 1'b0, '0);
    #3;
    for (int p = 0; p < NRD; p++) begin
      e = sb.pop_front(); n_run++;
      if (rd_data[p*XLEN +: XLEN] !== e.d || rd_busy[p] !== e.b
          || rd_tag[p*TAG_W +: TAG_W] !== e.t) begin
        n_fail++;
        $display("FAIL %s got d=%h b=%b t=%h want d=%h b=%b t=%h", e.nm,
          rd_data[p*XLEN +: XLEN], rd_busy[p], rd_tag[p*TAG_W +: TAG_W],
          e.d, e.b, e.t);
      end
    end
    n_run++;
    if (num_busy !== 6'd1) begin
      n_fail++;
      $display("FAIL stale_num_busy got %0d want 1", num_busy);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    idle(); ren(5'd6, 4'd1); step();
    idle(); cmt(5'd6, 32'h66, 4'd1); ren(5'd6, 4'd9); rd(5'd6, 5'd6);
    push("b2b_byp_p0", 32'h66, 1'b0, '0);
    push("b2b_byp_p1", 32'h66, 1'b0, '0);
    #3;
    for (int p = 0; p < NRD; p++) begin
      e = sb.pop_front(); n_run++;
      if (rd_data[p*XLEN +: XLEN] !== e.d || rd_busy[p] !== e.b
          || rd_tag[p*TAG_W +: TAG_W] !== e.t) begin
        n_fail++;
        $display("FAIL %s got d=%h b=%b t=%h want d=%h b=%b t=%h", e.nm,
          rd_data[p*XLEN +: XLEN], rd_busy[p], rd_tag[p*TAG_W +: TAG_W],
          e.d, e.b, e.t);
      end
    end
    step(); idle(); rd(5'd6, 5'd4);
    push("b2b_x6_p0", 32'h66, 1'b1, 4'd9);
    push("b2b_x4_p1", 32'h11, 1'b1, 4'd5);
    #3;
    for (int p = 0; p < NRD; p++) begin
      e = sb.pop_front(); n_run++;
      if (rd_data[p*XLEN +: XLEN] !== e.d || rd_busy[p] !== e.b
          || rd_tag[p*TAG_W +: TAG_W] !== e.t) begin
        n_fail++;
        $display("FAIL %s got d=%h b=%b t=%h want d=%h b=%b t=%h", e.nm,
          rd_data[p*XLEN +: XLEN], rd_busy[p], rd_tag[p*TAG_W +: TAG_W],
          e.d, e.b, e.t);
      end
    end
    n_run++;
    if (num_busy !== 6'd2) begin
      n_fail++;
      $display("FAIL b2b_num_busy got %0d want 2", num_busy);
    end
  endtask

  task automatic test_flush();
    exp_t e;
    idle(); ren(5'd1, 4'd1); step();
    ren(5'd2, 4'd2); step();
    ren(5'd7, 4'd3); step();
    idle();
    n_run++;
    if (num_busy !== 6'd5) begin
      n_fail++;
      $display("FAIL pre_flush_num_busy got %0d want 5", num_busy);
    end
    flush = 1'b1; ren(5'd8, 4'd4); cmt(5'd1, 32'h22, 4'd1);
    rd(5'd1, 5'd7);
    push("flush_x1_p0", 32'h22, 1'b0, '0);
    push("flush_x7_p1", '0, 1'b0, '0);
    #3;
    for (int p = 0; p < NRD; p++) begin
      e = sb.pop_front(); n_run++;
      if (rd_data[p*XLEN +: XLEN] !== e.d || rd_busy[p] !== e.b
          || rd_tag[p*TAG_W +: TAG_W] !== e.t) begin
        n_fail++;
        $display("FAIL %s got d=%h b=%b t=%h want d=%h b=%b t=%h", e.nm,
          rd_data[p*XLEN +: XLEN], rd_busy[p], rd_tag[p*TAG_W +: TAG_W],
          e.d, e.b, e.t);
      end
    end
    step(); idle(); rd(5'd1, 5'd8);
    push("post_flush_x1_p0", 32'h22, 1'b0, '0);
    push("post_flush_x8_p1", '0, 1'b0, '0);
    #3;
    for (int p = 0; p < NRD; p++) begin
      e = sb.pop_front(); n_run++;
      if (rd_data[p*XLEN +: XLEN] !== e.d || rd_busy[p] !== e.b
          || rd_tag[p*TAG_W +: TAG_W] !== e.t) begin
        n_fail++;
        $display("FAIL %s got d=%h b=%b t=%h want d=%h b=%b t=%h", e.nm,
          rd_data[p*XLEN +: XLEN], rd_busy[p], rd_tag[p*TAG_W +: TAG_W],
          e.d, e.b, e.t);
      end
    end
    n_run++;
    if (num_busy !== 6'd0) begin
      n_fail++;
      $display("FAIL flush_num_busy got %0d want 0", num_busy);
    end
  endtask

  task automatic test_x0_and_stall();
    exp_t e;
    idle(); cmt(5'd0, 32'hFF, 4'd0); ren(5'd0, 4'd3); step();
    idle(); rd(5'd0, 5'd0);
    push("x0_p0", '0, 1'b0, '0);
    push("x0_p1", '0, 1'b0, '0);
    #3;
    for (int p = 0; p < NRD; p++) begin
      e = sb.pop_front(); n_run++;
      if (rd_data[p*XLEN +: XLEN] !== e.d || rd_busy[p] !== e.b
          || rd_tag[p*TAG_W +: TAG_W] !== e.t) begin
        n_fail++;
        $display("FAIL %s got d=%h b=%b t=%h want d=%h b=%b t=%h", e.nm,
          rd_data[p*XLEN +: XLEN], rd_busy[p], rd_tag[p*TAG_W +: TAG_W],
          e.d, e.b, e.t);
      end
    end
    n_run++;
    if (num_busy !== 6'd0) begin
      n_fail++;
      $display("FAIL x0_num_busy got %0d want 0", num_busy);
    end
    ren(5'd10, 4'd6); step(); idle();
    rdy = 1'b0; ren(5'd9, 4'd5); cmt(5'd1, 32'h99, 4'd0);
    rd(5'd1, 5'd10);
    push("stall_nobyp_p0", 32'h22, 1'b0, '0);
    push("stall_x10_p1", '0, 1'b1, 4'd6);
    #3;
    for (int p = 0; p < NRD; p++) begin
      e = sb.pop_front(); n_run++;
      if (rd_data[p*XLEN +: XLEN] !== e.d || rd_busy[p] !== e.b
          || rd_tag[p*TAG_W +: TAG_W] !== e.t) begin
        n_fail++;
        $display("FAIL %s got d=%h b=%b t=%h want d=%h b=%b t=%h", e.nm,
          rd_data[p*XLEN +: XLEN], rd_busy[p], rd_tag[p*TAG_W +: TAG_W],
          e.d, e.b, e.t);
      end
    end
    step();
    flush = 1'b1; cmt(5'd10, 32'h77, 4'd6); rd(5'd9, 5'd10);
    push("stall_flush_x9_p0", '0, 1'b0, '0);
    push("stall_flush_x10_p1", '0, 1'b0, '0);
    #3;
    for (int p = 0; p < NRD; p++) begin
      e = sb.pop_front(); n_run++;
      if (rd_data[p*XLEN +: XLEN] !== e.d || rd_busy[p] !== e.b
          || rd_tag[p*TAG_W +: TAG_W] !== e.t) begin
        n_fail++;
        $display("FAIL %s got d=%h b=%b t=%h want d=%h b=%b t=%h", e.nm,
          rd_data[p*XLEN +: XLEN], rd_busy[p], rd_tag[p*TAG_W +: TAG_W],
          e.d, e.b, e.t);
      end
    end
    step(); idle(); rd(5'd10, 5'd1);
    push("stall_held_x10_p0", '0, 1'b1, 4'd6);
    push("stall_held_x1_p1", 32'h22, 1'b0, '0);
    #3;
    for (int p = 0; p < NRD; p++) begin
      e = sb.pop_front(); n_run++;
      if (rd_data[p*XLEN +: XLEN] !== e.d || rd_busy[p] !== e.b
          || rd_tag[p*TAG_W +: TAG_W] !== e.t) begin
        n_fail++;
        $display("FAIL %s got d=%h b=%b t=%h want d=%h b=%b t=%h", e.nm,
          rd_data[p*XLEN +: XLEN], rd_busy[p], rd_tag[p*TAG_W +: TAG_W],
          e.d, e.b, e.t);
      end
    end
    n_run++;
    if (num_busy !== 6'd1) begin
      n_fail++;
      $display("FAIL stall_num_busy got %0d want 1", num_busy);
    end
  endtask

  task automatic test_random();
    exp_t             e;
    logic [AW-1:0]    a;
    logic [XLEN-1:0]  d;
    logic             b;
    logic [TAG_W-1:0] t;
    int               cnt;
    idle(); rst = 1'b1; step(); rst = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      mval[r] = '0; mbusy[r] = 1'b0; mtag[r] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      rdy      = ($urandom_range(0, 9) != 0);
      flush    = ($urandom_range(0, 19) == 0);
      cmt_en   = $urandom_range(0, 1) == 1;
      cmt_addr = AW'($urandom_range(0, 7));
      cmt_data = $urandom;
      ren_en   = $urandom_range(0, 1) == 1;
      ren_addr = AW'($urandom_range(0, 7));
      ren_tag  = TAG_W'($urandom);
      cmt_tag  = ($urandom_range(0, 2) != 0) ? mtag[cmt_addr]
                                            : TAG_W'($urandom);
      rd_addr  = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      for (int p = 0; p < NRD; p++) begin
        a = rd_addr[p*AW +: AW];
        d = '0; b = 1'b0; t = '0;
        if (a != '0) begin
          d = (rdy && cmt_en && cmt_addr == a) ? cmt_data : mval[a];
          b = mbusy[a] && !flush;
          if (rdy && cmt_en && cmt_addr == a && mtag[a] == cmt_tag)
            b = 1'b0;
          t = b ? mtag[a] : '0;
        end
        push("rand_rd", d, b, t);
      end
      #3;
      for (int p = 0; p < NRD; p++) begin
        e = sb.pop_front(); n_run++;
        if (rd_data[p*XLEN +: XLEN] !== e.d || rd_busy[p] !== e.b
            || rd_tag[p*TAG_W +: TAG_W] !== e.t) begin
          n_fail++;
          $display("FAIL %s c%0d p%0d got d=%h b=%b t=%h want d=%h b=%b t=%h",
            e.nm, c, p, rd_data[p*XLEN +: XLEN], rd_busy[p],
            rd_tag[p*TAG_W +: TAG_W], e.d, e.b, e.t);
        end
      end
      if (rdy) begin
        if (cmt_en && cmt_addr != '0)
          mval[cmt_addr] = cmt_data;
        if (flush) begin
          for (int r = 0; r < NREGS; r++) begin
            mbusy[r] = 1'b0; mtag[r] = '0;
          end
        end else begin
          if (cmt_en && cmt_addr != '0 && mbusy[cmt_addr]
              && mtag[cmt_addr] == cmt_tag) begin
            mbusy[cmt_addr] = 1'b0; mtag[cmt_addr] = '0;
          end
          if (ren_en && ren_addr != '0) begin
            mbusy[ren_addr] = 1'b1; mtag[ren_addr] = ren_tag;
          end
        end
      end
      step();
      cnt = 0;
      for (int r = 0; r < NREGS; r++)
        if (mbusy[r]) cnt++;
      n_run++;
      if (num_busy !== (AW + 1)'(cnt)) begin
        n_fail++;
        $display("FAIL rand_num_busy c%0d got %0d want %0d", c, num_busy, cnt);
      end
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    idle();
    test_reset();
    test_rename_commit();
    test_tag_mismatch();
    test_back_to_back();
    test_flush();
    test_x0_and_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_status_file.md
REG_STATUS_FILE -- requirements
Module: reg_status_file

Interface
REQ-001 The block SHALL take parameter XLEN, default 32, meaning register data width.
REQ-002 The block SHALL take parameter NREGS, default 32, meaning architectural register count (power of two, >=2); AW = clog2(NREGS).
REQ-003 The block SHALL take parameter TAG_W, default 4, meaning reorder-buffer tag width.
REQ-004 The block SHALL take parameter NRD, default 2, meaning number of read ports (1..4).
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 rdy  in  1  global enable; low = freeze all state.
REQ-008 flush  in  1  mispredict flush; clears all rename state.
REQ-009 cmt_en  in  1  commit write valid.
REQ-010 cmt_addr  in  AW  commit destination register.
REQ-011 cmt_data  in  XLEN  commit value.
REQ-012 cmt_tag  in  TAG_W  ROB tag of committing instruction.
REQ-013 ren_en  in  1  rename valid (dispatch allocates destination).
REQ-014 ren_addr  in  AW  renamed destination register.
REQ-015 ren_tag  in  TAG_W  ROB tag assigned.
REQ-016 rd_addr  in  NRD*AW  packed read addresses, port i at [i*AW +: AW].
REQ-017 rd_data  out  NRD*XLEN  packed read values.
REQ-018 rd_busy  out  NRD  per-port: value pending in ROB.
REQ-019 rd_tag  out  NRD*TAG_W  per-port pending tag; 0 when not busy.
REQ-020 num_busy  out  AW+1  registered count of busy registers.

Function
REQ-021 State per register SHALL be: value[XLEN], busy bit, tag[TAG_W].
REQ-022 Register 0 SHALL never be written, never busy; reads return data 0, busy 0, tag 0.
REQ-023 Reads SHALL be combinational, zero latency, identical logic on every port.
REQ-024 Read bypass: cmt_en && rdy && rd_addr==cmt_addr!=0 SHALL return cmt_data; busy returned 0 if stored tag==cmt_tag, else stored busy/tag.
REQ-025 Reads SHALL NOT see a same-cycle rename (sources read before own destination renamed).
REQ-026 Commit (cmt_en, rdy, addr!=0) SHALL write value; SHALL clear busy only if busy && tag==cmt_tag.
REQ-027 Rename (ren_en, rdy, !flush, addr!=0) SHALL set busy=1, tag=ren_tag.
REQ-028 Commit and rename same cycle, same address: value written, busy=1, tag=ren_tag (rename wins).
REQ-029 flush && rdy SHALL clear every busy bit and tag next edge; same-cycle commit still writes value; same-cycle rename ignored.
REQ-030 While flush high, all rd_busy SHALL read 0 and rd_tag 0 (data path unchanged).
REQ-031 rdy low SHALL hold all state and num_busy; reads remain valid (no bypass).
REQ-032 num_busy SHALL equal popcount of busy bits after each edge, maintained by +1/-1/0 counter (rename of non-busy reg +1, clearing commit -1, both on same reg 0 net, re-rename of busy reg 0); flush sets 0.

Reset
REQ-033 rst SHALL zero all values, busy bits, tags and num_busy on the next edge, overriding rdy, flush, commit and rename.
REQ-034 During rst high, rd_data, rd_busy, rd_tag SHALL read 0.

Structure
REQ-035 Default XLEN, NREGS, TAG_W, NRD and derived AW SHALL live in the shared config package.
REQ-036 The per-port read/bypass logic SHALL be one sub-module, regfile_read_port, instantiated NRD times via generate.

Verification
REQ-037 Reset then read x5 on both ports -> data 0, busy 0, num_busy 0.
REQ-038 Rename x3 tag 7, next cycle read x3 -> busy 1, tag 7, num_busy 1; commit x3 data 0xDEADBEEF tag 7, same-cycle read -> 0xDEADBEEF busy 0; next cycle num_busy 0.
REQ-039 Rename x4 tag 2, rename x4 tag 5, commit x4 tag 2 data 0x11 -> value 0x11, busy 1, tag 5, num_busy 1.
REQ-040 Same cycle commit x6 tag 1 (busy tag 1) and rename x6 tag 9 -> x6 busy, tag 9, value written, num_busy unchanged.
REQ-041 Rename x1,x2,x7; flush with rename x8 and commit x1 data 0x22 -> all busy 0, num_busy 0, x1=0x22, x8 not busy.
REQ-042 Commit/rename x0 and any op with rdy=0 -> no state change; x0 reads 0.
